alu_interface: RTL and testbench
================================

# alu_interface

Operand/opcode sequencer that drives the `ALU` block from a serial word stream and returns its result to a transmitter. It collects three words (A, B, OP) from a receiver-side valid strobe and presents them on the ALU operand ports. It then waits a fixed ALU latency, latches the ALU result and hands it to a busy-gated transmitter. It sits between the UART receiver/transmitter pair and the `ALU` instance, replacing the switch/button front end.

## Interface

Parameters:
- `NB_DATA`, 6: operand/result/word width.
- `NB_OP`, 6: opcode width. Must be ≤ `NB_DATA`.
- `ALU_LAT`, 1: cycles from operands stable to ALU result valid. Must be ≥ 1.
- `TIMEOUT`, 1024: idle cycles allowed in WAIT_B/WAIT_OP. 0 disables the timeout.

Ports:
- `clock`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `i_rx_data`  in  NB_DATA: incoming word.
- `i_rx_valid`  in  1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_A`  out  NB_DATA: ALU operand A.
- `o_B`  out  NB_DATA: ALU operand B.
- `o_OP`  out  NB_OP: ALU opcode.
- `i_alu_result`  in  NB_DATA: ALU output.
- `o_tx_data`  out  NB_DATA: latched result for the transmitter.
- `o_tx_start`  out  1: one-cycle start pulse to the transmitter.
- `i_tx_busy`  in  1: transmitter busy. No start pulse is issued while it is high.
- `o_error`  out  1: one-cycle pulse on an invalid opcode or a timeout.
- `o_overrun`  out  1: one-cycle pulse when a word arrives in EXEC/SEND and is dropped.

## Operation

- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A, on `i_rx_valid`: `o_A` ← `i_rx_data`, then go to WAIT_B.
- WAIT_B, on `i_rx_valid`: `o_B` ← `i_rx_data`, then go to WAIT_OP.
- WAIT_OP, on `i_rx_valid`: decode `i_rx_data[NB_OP-1:0]`.
  - Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
  - Valid opcode: `o_OP` ← value, load the latency counter, go to EXEC.
  - Invalid opcode: `o_OP` unchanged, pulse `o_error`, go to WAIT_A.
- EXEC: count `ALU_LAT` cycles. On the last one, `o_tx_data` ← `i_alu_result`, then go to SEND.
- SEND: in the first cycle with `i_tx_busy`=0, pulse `o_tx_start` and go to WAIT_A. Otherwise hold in SEND with no timeout.
- Timeout: one counter, cleared on every accepted word and on entry to WAIT_B.
  - It increments each cycle in WAIT_B/WAIT_OP.
  - When it reaches `TIMEOUT`, pulse `o_error` and go to WAIT_A. A, B and OP are retained.
- `i_rx_valid` in EXEC or SEND: word dropped, `o_overrun` pulses, state unaffected.
- `i_rx_valid` in the same cycle as a timeout expiry: timeout wins and the word is discarded.
- `o_A`/`o_B`/`o_OP` hold their value until overwritten, so the ALU output stays stable through SEND.
- The result is truncated to `NB_DATA`; no carry or overflow is reported.

## Timing

- Reset values:
  - `o_A`, `o_B`, `o_OP`, `o_tx_data` = 0.
  - `o_tx_start`, `o_error`, `o_overrun` = 0.
  - State = WAIT_A; both counters = 0.
- A word accepted at edge n is visible on its output register after edge n.
- Opcode accepted at edge k: EXEC occupies cycles k+1 … k+ALU_LAT, and `o_tx_data` is loaded at edge k+ALU_LAT.
- `o_tx_start` is high in cycle k+ALU_LAT+1 if `i_tx_busy`=0 then; otherwise it is high in the first later cycle with `i_tx_busy`=0.
- Exactly one `o_tx_start` pulse per valid transaction.
- The next A word is accepted starting the cycle after `o_tx_start`.
- Reset mid-transaction (any state): all registers return to reset values on that edge. No `o_tx_start` or `o_error` is produced for the aborted transaction.

## Structure

- Shared package `alu_pkg`:
  - Opcode localparams (OP_ADD … OP_SRL).
  - State encoding.
  - `NB_DATA`/`NB_OP` defaults, which are shared with `ALU`.
- `ALU` imports the same opcode constants.
- One natural sub-module: `alu_op_check`, a combinational opcode-valid decoder that is reused by `ALU`'s default branch.
- Counters and FSM stay in `alu_interface`.

## Test plan

- ADD: rx 2, 3, 100000 with `ALU_LAT`=1 and busy=0 → `o_A`=2, `o_B`=3, `o_tx_data`=5, single `o_tx_start` 2 cycles after the opcode strobe.
- SUB then SRA back-to-back:
  - Words 6, 5, 100010 → tx 1.
  - Words 15, 1, 000011 → tx 7.
  - Required: no `o_error`, no `o_overrun`.
- Invalid opcode: rx 7, 7, 000000 → `o_error` pulse, no `o_tx_start`, `o_OP` unchanged. A following 5, 2, 100101 yields tx 7.
- Timeout with `TIMEOUT`=16: rx 8 then 16 idle cycles → `o_error` on the 16th, state WAIT_A. The next word is taken as A.
- Busy stall: ADD 1, 1 with `i_tx_busy` high for 10 cycles in SEND, plus an rx strobe during SEND → one `o_overrun`; `o_tx_start` in the first busy-low cycle, `o_tx_data`=2.
- Reset mid-EXEC with `ALU_LAT`=4: all outputs are 0 next cycle, no `o_tx_start`. A new ADD 2, 3 completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its serial front end: default widths,
// the opcode map and the sequencer state encoding.
package alu_pkg;

  localparam int NB_DATA_DEF = 6;
  localparam int NB_OP_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND
  } state_t;

endpackage

// File: rtl/alu_op_check.sv
// Combinational opcode-valid decoder; flags whether an opcode is one the ALU
// implements. Also used by the ALU to route unknown opcodes to its default.
module alu_op_check
  import alu_pkg::*;
#(
  parameter int NB_OP = NB_OP_DEF
) (
  input  logic [NB_OP-1:0] i_op,
  output logic             o_valid
);

  always_comb begin
    o_valid = 1'b0;
    case (i_op)
      NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
      NB_OP'(OP_XOR), NB_OP'(OP_NOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL):
        o_valid = 1'b1;
      default:
        o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_interface.sv
// Collects A, B and opcode words from the receiver, presents them to the ALU,
// waits the ALU latency, then hands the latched result to the transmitter.
module alu_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_A,
  output logic [NB_DATA-1:0] o_B,
  output logic [NB_OP-1:0]   o_OP,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic               o_error,
  output logic               o_overrun
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             r_state;
  logic [NB_DATA-1:0] r_A;
  logic [NB_DATA-1:0] r_B;
  logic [NB_OP-1:0]   r_OP;
  logic [NB_DATA-1:0] r_txData;
  logic               r_error;
  logic               r_overrun;
  logic [LAT_W-1:0]   r_latCnt;
  logic [TO_W-1:0]    r_toCnt;

  logic w_opValid;
  logic w_waitWord;
  logic w_timeout;
  logic w_sendGo;

  alu_op_check #(
    .NB_OP(NB_OP)
  ) u_op_check (
    .i_op   (i_rx_data[NB_OP-1:0]),
    .o_valid(w_opValid)
  );

  // The timeout counter holds the number of idle cycles already spent waiting,
  // so the cycle in which it equals TIMEOUT-1 is the last allowed one.
  assign w_waitWord = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
  assign w_timeout  = TO_EN && w_waitWord && (r_toCnt == TO_LAST);
  assign w_sendGo   = (r_state == ST_SEND) && !i_tx_busy;

  // Start fires in the same cycle the transmitter is seen idle; gated by reset
  // so an aborted transaction never reaches the transmitter.
  assign o_tx_start = w_sendGo && !reset;

  assign o_A       = r_A;
  assign o_B       = r_B;
  assign o_OP      = r_OP;
  assign o_tx_data = r_txData;
  assign o_error   = r_error;
  assign o_overrun = r_overrun;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_WAIT_A;
      r_A       <= '0;
      r_B       <= '0;
      r_OP      <= '0;
      r_txData  <= '0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
      r_latCnt  <= '0;
      r_toCnt   <= '0;
    end else begin
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
      // An expiring timeout takes priority over a word arriving in that cycle.
      if (w_timeout) begin
        r_error <= 1'b1;
        r_toCnt <= '0;
        r_state <= ST_WAIT_A;
      end else begin
        case (r_state)
          ST_WAIT_A: begin
            if (i_rx_valid) begin
              r_A     <= i_rx_data;
              r_toCnt <= '0;
              r_state <= ST_WAIT_B;
            end
          end
          ST_WAIT_B: begin
            if (i_rx_valid) begin
              r_B     <= i_rx_data;
              r_toCnt <= '0;
              r_state <= ST_WAIT_OP;
            end else if (TO_EN) begin
              r_toCnt <= r_toCnt + 1'b1;
            end
          end
          ST_WAIT_OP: begin
            if (i_rx_valid) begin
              r_toCnt <= '0;
              if (w_opValid) begin
                r_OP     <= i_rx_data[NB_OP-1:0];
                r_latCnt <= LAT_LAST;
                r_state  <= ST_EXEC;
              end else begin
                r_error <= 1'b1;
                r_state <= ST_WAIT_A;
              end
            end else if (TO_EN) begin
              r_toCnt <= r_toCnt + 1'b1;
            end
          end
          ST_EXEC: begin
            r_overrun <= i_rx_valid;
            if (r_latCnt == '0) begin
              r_txData <= i_alu_result;
              r_state  <= ST_SEND;
            end else begin
              r_latCnt <= r_latCnt - 1'b1;
            end
          end
          ST_SEND: begin
            r_overrun <= i_rx_valid;
            if (w_sendGo) begin
              r_state <= ST_WAIT_A;
            end
          end
          default: begin
            r_state <= ST_WAIT_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_interface.sv
// Self-checking bench for alu_interface: a table of hand-computed transactions,
// timeout and reset corner sequences, then random transactions vs. a reference ALU.
module tb_alu_interface;

  localparam int TO = 16;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] op;
    int         gap;
    int         busyCyc;
    bit         inject;
    bit         expValid;
    logic [5:0] expTx;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxValid;
  logic       busy;
  logic [5:0] rxData;
  logic       sel4;

  logic [5:0] a1, b1, op1, res1, tx1;
  logic       start1, err1, ovr1;
  logic [5:0] a4, b4, op4, res4, tx4;
  logic       start4, err4, ovr4;
  logic [5:0] pipe4 [3];

  logic [5:0] sA, sB, sOp, sTx;
  logic       sStart, sErr, sOvr;

  int         nVec = 0;
  int         nMis = 0;
  logic [5:0] lastOp;
  logic [5:0] validOps [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100110, 6'b100111, 6'b000011, 6'b000010};

  always #5 clock = ~clock;

  alu_interface #(.NB_DATA(6), .NB_OP(6), .ALU_LAT(1), .TIMEOUT(TO)) dut1 (
    .clock(clock), .reset(reset), .i_rx_data(rxData), .i_rx_valid(rxValid),
    .o_A(a1), .o_B(b1), .o_OP(op1), .i_alu_result(res1), .o_tx_data(tx1),
    .o_tx_start(start1), .i_tx_busy(busy), .o_error(err1), .o_overrun(ovr1)
  );

  alu_interface #(.NB_DATA(6), .NB_OP(6), .ALU_LAT(4), .TIMEOUT(TO)) dut4 (
    .clock(clock), .reset(reset), .i_rx_data(rxData), .i_rx_valid(rxValid),
    .o_A(a4), .o_B(b4), .o_OP(op4), .i_alu_result(res4), .o_tx_data(tx4),
    .o_tx_start(start4), .i_tx_busy(busy), .o_error(err4), .o_overrun(ovr4)
  );

  function automatic logic [5:0] aluRef(input logic [5:0] a, input logic [5:0] b,
                                        input logic [5:0] op);
    logic signed [5:0] sa;
    sa = a;
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return sa >>> b;
      6'b000010: return a >> b;
      default:   return 6'd0;
    endcase
  endfunction

  function automatic bit isValid(input logic [5:0] op);
    foreach (validOps[i]) if (validOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Latency-1 ALU is combinational; the latency-4 ALU is a three-register pipe.
  assign res1 = aluRef(a1, b1, op1);
  always @(posedge clock) begin
    pipe4[0] <= aluRef(a4, b4, op4);
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end
  assign res4 = pipe4[2];

  assign sA     = sel4 ? a4 : a1;
  assign sB     = sel4 ? b4 : b1;
  assign sOp    = sel4 ? op4 : op1;
  assign sTx    = sel4 ? tx4 : tx1;
  assign sStart = sel4 ? start4 : start1;
  assign sErr   = sel4 ? err4 : err1;
  assign sOvr   = sel4 ? ovr4 : ovr1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset  = 1'b0;
    lastOp = 6'd0;
  endtask

  task automatic sendWord(input logic [5:0] w, input int gap);
    rxData  = w;
    rxValid = 1'b1;
    @(posedge clock); #1;
    rxValid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  // One full transaction; observes a bounded window after the opcode strobe.
  task automatic applyStimulus(input string name, input vec_t v);
    int lat, win, nStart, startCyc, nErr, nOvr;
    logic [5:0] txAtStart, expOp;
    lat   = sel4 ? 4 : 1;
    expOp = v.expValid ? v.op : lastOp;
    sendWord(v.a, v.gap);
    sendWord(v.b, v.gap);
    sendWord(v.op, 0);
    win = lat + v.busyCyc + 4;
    nStart = 0; startCyc = -1; nErr = 0; nOvr = 0; txAtStart = 6'd0;
    for (int c = 1; c <= win; c++) begin
      busy = (v.busyCyc > 0) && (c < lat + 1 + v.busyCyc);
      if (v.inject && c == lat + 2) begin
        rxData  = 6'h2a;
        rxValid = 1'b1;
      end else begin
        rxValid = 1'b0;
      end
      @(negedge clock);
      if (sStart) begin
        nStart++;
        startCyc  = c;
        txAtStart = sTx;
      end
      nErr += int'(sErr);
      nOvr += int'(sOvr);
      @(posedge clock); #1;
    end
    rxValid = 1'b0;
    busy    = 1'b0;
    checkOutput({name, " o_A"}, sA, v.a);
    checkOutput({name, " o_B"}, sB, v.b);
    checkOutput({name, " o_OP"}, sOp, expOp);
    checkOutput({name, " start count"}, nStart, v.expValid ? 1 : 0);
    checkOutput({name, " error count"}, nErr, v.expValid ? 0 : 1);
    checkOutput({name, " overrun count"}, nOvr, v.inject ? 1 : 0);
    if (v.expValid) begin
      checkOutput({name, " start cycle"}, startCyc, lat + 1 + v.busyCyc);
      checkOutput({name, " tx data"}, txAtStart, v.expTx);
      lastOp = v.op;
    end
  endtask

  vec_t tbl [13];

  initial begin
    int errCyc, nErr, nStart1, nStart4, nErr4;
    vec_t v;

    tbl[0]  = '{6'd2,  6'd3,  6'b100000, 0,  0,  1'b0, 1'b1, 6'd5};
    tbl[1]  = '{6'd6,  6'd5,  6'b100010, 0,  0,  1'b0, 1'b1, 6'd1};
    tbl[2]  = '{6'd15, 6'd1,  6'b000011, 0,  0,  1'b0, 1'b1, 6'd7};
    tbl[3]  = '{6'd7,  6'd7,  6'b000000, 0,  0,  1'b0, 1'b0, 6'd0};
    tbl[4]  = '{6'd5,  6'd2,  6'b100101, 0,  0,  1'b0, 1'b1, 6'd7};
    tbl[5]  = '{6'd1,  6'd1,  6'b100000, 0,  10, 1'b1, 1'b1, 6'd2};
    tbl[6]  = '{6'd3,  6'd4,  6'b100111, 1,  0,  1'b0, 1'b1, 6'd56};
    tbl[7]  = '{6'd40, 6'd2,  6'b000011, 0,  2,  1'b0, 1'b1, 6'd58};
    tbl[8]  = '{6'd40, 6'd2,  6'b000010, 0,  0,  1'b0, 1'b1, 6'd10};
    tbl[9]  = '{6'd2,  6'd5,  6'b100010, 14, 0,  1'b0, 1'b1, 6'd61};
    tbl[10] = '{6'd63, 6'd1,  6'b100000, 0,  1,  1'b0, 1'b1, 6'd0};
    tbl[11] = '{6'd21, 6'd42, 6'b100110, 2,  0,  1'b0, 1'b1, 6'd63};
    tbl[12] = '{6'd60, 6'd15, 6'b100100, 0,  0,  1'b0, 1'b1, 6'd12};

    reset = 1'b1; rxValid = 1'b0; busy = 1'b0; rxData = 6'd0; sel4 = 1'b0;
    lastOp = 6'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset o_A", a1, 0);
    checkOutput("reset o_B", b1, 0);
    checkOutput("reset o_OP", op1, 0);
    checkOutput("reset o_tx_data", tx1, 0);
    checkOutput("reset flags", {start1, err1, ovr1}, 0);
    checkOutput("reset lat4 outputs", {a4, b4, op4, tx4, start4, err4, ovr4}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    foreach (tbl[i]) applyStimulus($sformatf("vec%0d", i), tbl[i]);

    // Timeout: A accepted, then TIMEOUT idle cycles expire in WAIT_B.
    sendWord(6'd8, 0);
    errCyc = -1; nErr = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (err1) begin
        nErr++;
        errCyc = c;
      end
      @(posedge clock); #1;
    end
    checkOutput("timeout error count", nErr, 1);
    checkOutput("timeout error cycle", errCyc, TO + 1);
    checkOutput("timeout A retained", a1, 8);
    applyStimulus("after timeout", '{6'd5, 6'd2, 6'b100101, 0, 0, 1'b0, 1'b1, 6'd7});

    // A word arriving in the expiry cycle is discarded.
    sendWord(6'd9, 0);
    repeat (TO - 1) begin
      @(posedge clock); #1;
    end
    rxData = 6'd33; rxValid = 1'b1;
    @(posedge clock); #1;
    rxValid = 1'b0;
    @(negedge clock);
    checkOutput("expiry word error", err1, 1);
    checkOutput("expiry word dropped", b1, 2);
    @(posedge clock); #1;
    applyStimulus("after expiry", '{6'd4, 6'd4, 6'b100000, 0, 0, 1'b0, 1'b1, 6'd8});

    for (int t = 0; t < 40; t++) begin
      v.a  = 6'($urandom);
      v.b  = 6'($urandom);
      v.op = ($urandom_range(0, 9) < 8) ? validOps[$urandom_range(0, 7)] : 6'($urandom);
      v.gap      = $urandom_range(0, 3);
      v.busyCyc  = $urandom_range(0, 3);
      v.inject   = 1'b0;
      v.expValid = isValid(v.op);
      v.expTx    = aluRef(v.a, v.b, v.op);
      applyStimulus($sformatf("rand%0d", t), v);
    end

    // Reset during EXEC of the latency-4 instance aborts the transaction.
    doReset();
    sel4 = 1'b1;
    sendWord(6'd9, 0);
    sendWord(6'd9, 0);
    sendWord(6'b100000, 0);
    nStart1 = 0; nStart4 = 0; nErr4 = 0;
    for (int c = 1; c <= 10; c++) begin
      reset = (c == 2);
      @(negedge clock);
      nStart1 += int'(start1);
      nStart4 += int'(start4);
      nErr4   += int'(err4);
      if (c == 3) begin
        checkOutput("midexec reset operands", {a4, b4, op4}, 0);
        checkOutput("midexec reset tx_data", tx4, 0);
        checkOutput("midexec reset flags", {start4, err4, ovr4}, 0);
      end
      @(posedge clock); #1;
    end
    reset  = 1'b0;
    lastOp = 6'd0;
    checkOutput("midexec lat4 starts", nStart4, 0);
    checkOutput("midexec lat4 errors", nErr4, 0);
    checkOutput("midexec lat1 starts", nStart1, 0);
    applyStimulus("lat4 after reset", '{6'd2, 6'd3, 6'b100000, 0, 0, 1'b0, 1'b1, 6'd5});
    applyStimulus("lat4 busy", '{6'd6, 6'd5, 6'b100010, 0, 3, 1'b1, 1'b1, 6'd1});

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
